// File: rtl/image_filter_3x3.sv
// image_filter_3x3 -- streaming 3x3 Sobel / passthrough filter for raster video.
//
// Ports
//   iCLK     sole clock, rising edge
//   iRST     synchronous active-high reset
//   iDATA    input pixel, raster order
//   iDVAL    iDATA valid this cycle (gaps allowed anywhere)
//   iSOF     qualified by iDVAL: pixel (0,0) of a frame; restarts the frame
//   iMODE    00 centre pixel, 01 |Gx|, 10 |Gy|, 11 |Gx|+|Gy|
//   iBIN     1 = binarise result against iTHRESH
//   iTHRESH  binarisation threshold
//   oDATA    filtered pixel for the window centred at (row-1, col-1)
//   oDVAL    oDATA valid, 2 cycles after the beat that completes the window
//   oSOF     with oDVAL for the first interior output (centre (1,1)) only
//
// iMODE/iBIN/iTHRESH are captured on each SOF beat and held for the frame.
module image_filter_3x3 #(
  parameter int DATA_W = 12,
  parameter int LINE_W = 640,
  parameter int SHIFT  = 0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [1:0]        iMODE,
  input  logic              iBIN,
  input  logic [DATA_W-1:0] iTHRESH,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic              oSOF
);

  localparam int COL_W = $clog2(LINE_W);
  localparam int GW    = DATA_W + 4;
  localparam int RW    = DATA_W + 5;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [RW-1:0]    SAT_MAX  = {5'b0, {DATA_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  // Row only matters up to "2" and ">2", so it saturates at 3.
  logic [1:0]         row_q, row_d;
  logic [COL_W-1:0]   pos_col;
  logic [1:0]         pos_row;
  logic               accept, win_done, first_win;

  logic [1:0]         mode_q;
  logic               bin_q;
  logic [DATA_W-1:0]  thr_q;

  logic [DATA_W-1:0]  lb1_mem [LINE_W];
  logic [DATA_W-1:0]  lb2_mem [LINE_W];
  logic [DATA_W-1:0]  lb1_rd, lb2_rd;
  logic [DATA_W-1:0]  win_q [3][3];

  logic               s1_vld_q, s1_sof_q, s1_bin_q;
  logic [1:0]         s1_mode_q;
  logic [DATA_W-1:0]  s1_thr_q;
  logic               s2_vld_q, s2_sof_q, s2_bin_q;
  logic [RW-1:0]      s2_res_q;
  logic [DATA_W-1:0]  s2_thr_q;
  logic               dval_q, sof_q;
  logic [DATA_W-1:0]  data_q;

  logic [GW-1:0]      gx_pos, gx_neg, gy_pos, gy_neg, gx_abs, gy_abs;
  logic [RW-1:0]      res_d, shifted;
  logic [DATA_W-1:0]  sat, out_d;

  // ---------------- window FSM: state register ----------------
  // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---------------- window FSM: next state ----------------
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (iDVAL && iSOF)
      state_d = S_FILL;
    else if (iDVAL && state_q != S_IDLE)
      state_d = (row_q >= 2'd2 && col_q >= COL_TWO) ? S_RUN : S_FILL;
  end

  // ---------------- window FSM: outputs ----------------
  // An SOF beat is pixel (0,0) whatever the counters say.
  always_comb begin
    accept    = iDVAL && (iSOF || state_q != S_IDLE);
    pos_col   = iSOF ? '0 : col_q;
    pos_row   = iSOF ? '0 : row_q;
    win_done  = accept && (state_d == S_RUN);
    first_win = win_done && (pos_row == 2'd2) && (pos_col == COL_TWO);
  end

  // ---------------- raster counters ----------------
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == 2'd3) ? 2'd3 : pos_row + 2'd1;
      end else begin
        col_d = pos_col + COL_W'(1);
        row_d = pos_row;
      end
    end
  end

  // ---------------- line buffers ----------------
  // lb1 holds row-1, lb2 holds row-2 at each column; the read-before-write
  // cascade moves a pixel down one line each time its column comes round.
  assign lb1_rd = lb1_mem[pos_col];
  assign lb2_rd = lb2_mem[pos_col];

  // NOTE: RAM contents are never reset; FILL gating keeps stale entries out of
  // any output, and a reset would prevent RAM inference.
  always_ff @(posedge iCLK) begin
    if (accept) begin
      lb1_mem[pos_col] <= iDATA;
      lb2_mem[pos_col] <= lb1_rd;
    end
  end

  // ---------------- 3x3 window + datapath registers (no reset needed) -----
  // win_q[r][c]: r=0 is row-2 (top), c=2 is the newest column.
  always_ff @(posedge iCLK) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb2_rd;
      win_q[1][2] <= lb1_rd;
      win_q[2][2] <= iDATA;
    end
    // Frame settings travel with each result so a new SOF cannot alter
    // results already in flight.
    if (win_done) begin
      s1_mode_q <= mode_q;
      s1_bin_q  <= bin_q;
      s1_thr_q  <= thr_q;
    end
    s2_res_q <= res_d;
    s2_bin_q <= s1_bin_q;
    s2_thr_q <= s1_thr_q;
  end

  // ---------------- control registers ----------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      col_q    <= '0;
      row_q    <= '0;
      mode_q   <= 2'b00;
      bin_q    <= 1'b0;
      thr_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_sof_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_sof_q <= 1'b0;
      dval_q   <= 1'b0;
      sof_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept && iSOF) begin
        mode_q <= iMODE;
        bin_q  <= iBIN;
        thr_q  <= iTHRESH;
      end
      s1_vld_q <= win_done;
      s1_sof_q <= first_win;
      s2_vld_q <= s1_vld_q;
      s2_sof_q <= s1_sof_q;
      dval_q   <= s2_vld_q;
      sof_q    <= s2_sof_q;
      data_q   <= out_d;
    end
  end

  // ---------------- stage 1: Sobel magnitudes ----------------
  // Each side of Gx/Gy is a non-negative sum, so |G| is a plain
  // larger-minus-smaller; the sign itself is never needed.
  assign gx_pos = GW'(win_q[0][2]) + (GW'(win_q[1][2]) << 1) + GW'(win_q[2][2]);
  assign gx_neg = GW'(win_q[0][0]) + (GW'(win_q[1][0]) << 1) + GW'(win_q[2][0]);
  assign gy_pos = GW'(win_q[2][0]) + (GW'(win_q[2][1]) << 1) + GW'(win_q[2][2]);
  assign gy_neg = GW'(win_q[0][0]) + (GW'(win_q[0][1]) << 1) + GW'(win_q[0][2]);
  assign gx_abs = (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
  assign gy_abs = (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;

  always_comb begin
    res_d = '0;
    case (s1_mode_q)
      2'b00:   res_d = RW'(win_q[1][1]);
      2'b01:   res_d = RW'(gx_abs);
      2'b10:   res_d = RW'(gy_abs);
      default: res_d = RW'(gx_abs) + RW'(gy_abs);
    endcase
  end

  // ---------------- stage 2: shift, saturate, binarise ----------------
  assign shifted = s2_res_q >> SHIFT;
  assign sat     = (shifted > SAT_MAX) ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
  assign out_d   = s2_bin_q ? ((sat >= s2_thr_q) ? {DATA_W{1'b1}} : {DATA_W{1'b0}}) : sat;

  assign oDATA = data_q;
  assign oDVAL = dval_q;
  assign oSOF  = sof_q;

endmodule

// File: tb/tb_image_filter_3x3.sv
// tb_image_filter_3x3 -- randomized self-checking bench for image_filter_3x3.
// A frame-image reference model computes each interior output from its
// 3x3 neighbourhood and schedules it for 2 cycles after the completing beat.
module tb_image_filter_3x3;

  localparam int DW   = 12;
  localparam int LW   = 8;
  localparam int SH   = 0;
  localparam int MAXV = (1 << DW) - 1;

  logic          iCLK = 1'b0;
  logic          iRST, iDVAL, iSOF, iBIN;
  logic [DW-1:0] iDATA, iTHRESH;
  logic [1:0]    iMODE;
  logic [DW-1:0] oDATA;
  logic          oDVAL, oSOF;

  image_filter_3x3 #(.DATA_W(DW), .LINE_W(LW), .SHIFT(SH)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
    .iMODE(iMODE), .iBIN(iBIN), .iTHRESH(iTHRESH),
    .oDATA(oDATA), .oDVAL(oDVAL), .oSOF(oSOF)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int data; bit sof; } exp_t;
  exp_t exp_q[$];

  bit m_active = 1'b0;
  int m_row, m_col, m_mode, m_thr;
  bit m_bin;
  int img [64][LW];
  int n_out = 0;
  int n_sof = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_pixel(input int y, input int x);
    int gx, gy, v;
    gx = (img[y-1][x+1] + 2*img[y][x+1] + img[y+1][x+1])
       - (img[y-1][x-1] + 2*img[y][x-1] + img[y+1][x-1]);
    gy = (img[y+1][x-1] + 2*img[y+1][x] + img[y+1][x+1])
       - (img[y-1][x-1] + 2*img[y-1][x] + img[y-1][x+1]);
    case (m_mode)
      0:       v = img[y][x];
      1:       v = iabs(gx);
      2:       v = iabs(gy);
      default: v = iabs(gx) + iabs(gy);
    endcase
    v = v >> SH;
    if (v > MAXV) v = MAXV;
    if (m_bin) v = (v >= m_thr) ? MAXV : 0;
    return v;
  endfunction

  // Called at posedge+2 of cycle cyc; the beat is sampled at edge cyc+1
  // and its result must appear after edge cyc+3.
  task automatic model_beat(input bit sof, input int d);
    exp_t e;
    if (sof) begin
      m_active = 1'b1;
      m_row = 0;
      m_col = 0;
      m_mode = int'(iMODE);
      m_bin  = iBIN;
      m_thr  = int'(iTHRESH);
    end else if (!m_active) begin
      return;
    end
    img[m_row][m_col] = d;
    if (m_row >= 2 && m_col >= 2) begin
      e.due  = cyc + 3;
      e.data = ref_pixel(m_row - 1, m_col - 1);
      e.sof  = (m_row == 2 && m_col == 2);
      exp_q.push_back(e);
    end
    m_col++;
    if (m_col == LW) begin
      m_col = 0;
      if (m_row < 63) m_row++;
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge iCLK) begin : mon
    bit   exp_now;
    exp_t e;
    exp_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (oDVAL) begin
      n_out++;
      if (oSOF) n_sof++;
    end
    if (oDVAL || exp_now) begin
      check("out_dval", int'(oDVAL), int'(exp_now));
      if (exp_now) begin
        e = exp_q.pop_front();
        if (oDVAL) begin
          check("out_data", int'(oDATA), e.data);
          check("out_sof", int'(oSOF), int'(e.sof));
        end
      end
    end
    if (oSOF && !oDVAL) check("sof_without_dval", int'(oSOF), 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input bit dval, input bit sof, input int d);
    @(posedge iCLK);
    #2;
    iDVAL = dval;
    iSOF  = sof;
    iDATA = DW'(d);
    if (dval) model_beat(sof, d);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0);
  endtask

  function automatic int gen_pix(input int kind, input int c);
    case (kind)
      0:       return 100;
      1:       return (c < 4) ? 0 : 100;
      2:       return (c < 4) ? 0 : MAXV;
      3:       return 10 * c;
      default: return int'($urandom_range(MAXV));
    endcase
  endfunction

  // npix raster beats starting with SOF; at beat chg_at the mode/bin/thresh
  // inputs are scrambled, which must have no effect on this frame.
  task automatic run_frame(input int npix, input int kind, input int mode, input bit bin,
                           input int thr, input int gap_pct, input int chg_at);
    iMODE   = 2'(mode);
    iBIN    = bin;
    iTHRESH = DW'(thr);
    for (int i = 0; i < npix; i++) begin
      if (i == chg_at) begin
        iMODE   = 2'(mode ^ 3);
        iBIN    = ~bin;
        iTHRESH = DW'($urandom_range(MAXV));
      end
      while (int'($urandom_range(99)) < gap_pct) tick(1'b0, 1'b0, 0);
      tick(1'b1, (i == 0), gen_pix(kind, i % LW));
    end
  endtask

  // ---------------- main sequence ----------------
  int base, sbase;

  initial begin
    iRST = 1'b1; iDVAL = 1'b0; iSOF = 1'b0; iDATA = '0;
    iMODE = 2'b00; iBIN = 1'b0; iTHRESH = '0;
    repeat (3) @(posedge iCLK);
    #2;
    check("rst_dval", int'(oDVAL), 0);
    check("rst_sof",  int'(oSOF),  0);
    check("rst_data", int'(oDATA), 0);
    iRST = 1'b0;

    // Beats before any SOF are ignored.
    base = n_out;
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b0, int'($urandom_range(MAXV)));
    drain(6);
    check("pre_sof_ignored", n_out - base, 0);

    // Flat frame, 6 rows, mode 11: 24 zeros, one oSOF.
    base = n_out; sbase = n_sof;
    run_frame(6*LW, 0, 3, 1'b0, 0, 0, -1);
    drain(6);
    check("flat_count", n_out - base, (LW-2)*4);
    check("flat_sof",   n_sof - sbase, 1);

    // Vertical step 0/100, mode 01 then mode 10.
    base = n_out;
    run_frame(4*LW, 1, 1, 1'b0, 0, 0, -1);
    drain(6);
    check("step_gx_count", n_out - base, (LW-2)*2);
    base = n_out;
    run_frame(4*LW, 1, 2, 1'b0, 0, 0, -1);
    drain(6);
    check("step_gy_count", n_out - base, (LW-2)*2);

    // Step 0/4095: saturation, then binarised at 2000.
    run_frame(4*LW, 2, 1, 1'b0, 0, 0, -1);
    drain(6);
    run_frame(4*LW, 2, 1, 1'b1, 2000, 0, -1);
    drain(6);

    // Ramp, passthrough, random iDVAL gaps.
    base = n_out;
    run_frame(5*LW, 3, 0, 1'b0, 0, 40, -1);
    drain(6);
    check("ramp_count", n_out - base, (LW-2)*3);

    // Mode scrambled mid-frame, then a second SOF at row 3.
    base = n_out; sbase = n_sof;
    run_frame(3*LW, 4, 3, 1'b0, 0, 20, 10);
    run_frame(4*LW, 4, 1, 1'b0, 0, 20, 5);
    drain(6);
    check("restart_count", n_out - base, (LW-2)*1 + (LW-2)*2);
    check("restart_sof",   n_sof - sbase, 2);

    // Reset mid-row with results in flight.
    run_frame(2*LW + 5, 4, 3, 1'b0, 0, 0, -1);
    @(posedge iCLK);
    #2;
    iRST = 1'b1; iDVAL = 1'b0; iSOF = 1'b0;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due >= cyc + 1) void'(exp_q.pop_back());
    m_active = 1'b0;
    @(posedge iCLK);
    #1;
    check("rst_mid_dval", int'(oDVAL), 0);
    iRST = 1'b0;
    base = n_out;
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, int'($urandom_range(MAXV)));
    drain(6);
    check("post_rst_ignored", n_out - base, 0);
    base = n_out;
    run_frame(5*LW, 4, 3, 1'b0, 0, 15, -1);
    drain(6);
    check("post_rst_count", n_out - base, (LW-2)*3);

    // Random frames with random settings and gaps.
    for (int f = 0; f < 5; f++) begin
      int rows;
      rows = int'($urandom_range(3, 7));
      base = n_out;
      run_frame(rows*LW, 4, int'($urandom_range(3)), 1'($urandom_range(1)),
                int'($urandom_range(MAXV)), 25, -1);
      drain(6);
      check("rand_count", n_out - base, (LW-2)*(rows-2));
    end

    drain(4);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
